// File: rtl/pipelined_carry_select_adder_pkg.sv
// Shared sizing helpers for the pipelined carry-select adder: slice count and
// width of the (possibly narrower) final slice.
package pipelined_carry_select_adder_pkg;

    function automatic int unsigned csa_num_blocks(input int unsigned width, input int unsigned block);
        return (width + block - 1) / block;
    endfunction

    function automatic int unsigned csa_last_block(input int unsigned width, input int unsigned block);
        return ((width % block) == 0) ? block : (width % block);
    endfunction

endpackage

// File: rtl/pipelined_carry_select_adder_slice.sv
// One carry-select slice: two W-bit ripple adders evaluated with carry-in 0
// and carry-in 1 so the later select chain only has to pick one.
module pipelined_carry_select_adder_slice #(
    parameter int W = 4
) (
    input  logic [W-1:0] i_a,
    input  logic [W-1:0] i_b,
    output logic [W-1:0] o_s0,
    output logic         o_c0,
    output logic [W-1:0] o_s1,
    output logic         o_c1
);

    logic w_k0;
    logic w_k1;

    always_comb begin
        w_k0 = 1'b0;
        w_k1 = 1'b1;
        o_s0 = '0;
        o_s1 = '0;
        for (int i = 0; i < W; i++) begin
            o_s0[i] = i_a[i] ^ i_b[i] ^ w_k0;
            w_k0    = (i_a[i] & i_b[i]) | (w_k0 & (i_a[i] ^ i_b[i]));
            o_s1[i] = i_a[i] ^ i_b[i] ^ w_k1;
            w_k1    = (i_a[i] & i_b[i]) | (w_k1 & (i_a[i] ^ i_b[i]));
        end
        o_c0 = w_k0;
        o_c1 = w_k1;
    end

endmodule

// File: rtl/pipelined_carry_select_adder.sv
// Two-stage pipelined carry-select adder with valid/ready flow control.
// Define CSA_OVERFLOW_EN to add the registered signed-overflow output.
module pipelined_carry_select_adder
    import pipelined_carry_select_adder_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int BLOCK = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    input  logic             carryin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             carryout
`ifdef CSA_OVERFLOW_EN
    ,
    output logic             overflow
`endif
);

    localparam int NB = int'(csa_num_blocks(WIDTH, BLOCK));
    localparam int LB = int'(csa_last_block(WIDTH, BLOCK));

    logic [WIDTH-1:0] w_s0;
    logic [WIDTH-1:0] w_s1;
    logic [NB-1:0]    w_c0;
    logic [NB-1:0]    w_c1;

    for (genvar k = 0; k < NB; k++) begin : g_slice
        localparam int LO = k * BLOCK;
        localparam int SW = (k == NB - 1) ? LB : BLOCK;
        pipelined_carry_select_adder_slice #(.W(SW)) u_slice (
            .i_a  (x[LO +: SW]),
            .i_b  (y[LO +: SW]),
            .o_s0 (w_s0[LO +: SW]),
            .o_c0 (w_c0[k]),
            .o_s1 (w_s1[LO +: SW]),
            .o_c1 (w_c1[k])
        );
    end

    // A stage advances when it is empty or its contents move on this cycle;
    // input transfers on in_valid & in_ready, output retires on out_valid & out_ready.
    logic w_en1;
    logic w_en2;

    logic             r_s1_valid;
    logic [WIDTH-1:0] r_s0;
    logic [WIDTH-1:0] r_s1;
    logic [NB-1:0]    r_c0;
    logic [NB-1:0]    r_c1;
    logic             r_cin;

    logic             r_out_valid;
    logic [WIDTH-1:0] r_sum;
    logic             r_cout;

    assign w_en2    = !r_out_valid || out_ready;
    assign w_en1    = !r_s1_valid || w_en2;
    assign in_ready = w_en1;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1_valid <= 1'b0;
            r_s0       <= '0;
            r_s1       <= '0;
            r_c0       <= '0;
            r_c1       <= '0;
            r_cin      <= 1'b0;
        end else if (w_en1) begin
            r_s1_valid <= in_valid;
            if (in_valid) begin
                r_s0  <= w_s0;
                r_s1  <= w_s1;
                r_c0  <= w_c0;
                r_c1  <= w_c1;
                r_cin <= carryin;
            end
        end
    end

    logic [NB:0]      w_c;
    logic [WIDTH-1:0] w_sum;

    always_comb begin
        w_c    = '0;
        w_c[0] = r_cin;
        for (int k = 0; k < NB; k++) begin
            w_c[k+1] = w_c[k] ? r_c1[k] : r_c0[k];
        end
        w_sum = '0;
        for (int i = 0; i < WIDTH; i++) begin
            w_sum[i] = w_c[i / BLOCK] ? r_s1[i] : r_s0[i];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_valid <= 1'b0;
            r_sum       <= '0;
            r_cout      <= 1'b0;
        end else if (w_en2) begin
            r_out_valid <= r_s1_valid;
            if (r_s1_valid) begin
                r_sum  <= w_sum;
                r_cout <= w_c[NB];
            end
        end
    end

`ifdef CSA_OVERFLOW_EN
    // Carry into the MSB is recovered as sum_msb ^ x_msb ^ y_msb.
    logic r_msb_xor;
    logic r_ovf;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_msb_xor <= 1'b0;
        end else if (w_en1 && in_valid) begin
            r_msb_xor <= x[WIDTH-1] ^ y[WIDTH-1];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ovf <= 1'b0;
        end else if (w_en2 && r_s1_valid) begin
            r_ovf <= w_sum[WIDTH-1] ^ r_msb_xor ^ w_c[NB];
        end
    end

    assign overflow = r_ovf;
`endif

    assign out_valid = r_out_valid;
    assign sum       = r_sum;
    assign carryout  = r_cout;

endmodule

// File: tb/tb_pipelined_carry_select_adder.sv
// Scoreboard bench: a 16/4 instance and a 10/4 instance (narrow last slice),
// directed vectors with hand-computed results plus a backpressured stream.
module tb_pipelined_carry_select_adder;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;

    logic        a_in_valid, a_in_ready, a_cin, a_out_valid, a_out_ready, a_cout, a_ovf;
    logic [15:0] a_x, a_y, a_sum;
    logic        b_in_valid, b_in_ready, b_cin, b_out_valid, b_out_ready, b_cout, b_ovf;
    logic [9:0]  b_x, b_y, b_sum;

    int n_vec = 0;
    int n_err = 0;
    int rdy_mode = 0;

    logic [17:0] exp_a[$];
    logic [11:0] exp_b[$];

    pipelined_carry_select_adder #(.WIDTH(16), .BLOCK(4)) u_dut_a (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (a_in_valid),
        .in_ready  (a_in_ready),
        .x         (a_x),
        .y         (a_y),
        .carryin   (a_cin),
        .out_valid (a_out_valid),
        .out_ready (a_out_ready),
        .sum       (a_sum),
`ifdef CSA_OVERFLOW_EN
        .overflow  (a_ovf),
`endif
        .carryout  (a_cout)
    );

    pipelined_carry_select_adder #(.WIDTH(10), .BLOCK(4)) u_dut_b (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (b_in_valid),
        .in_ready  (b_in_ready),
        .x         (b_x),
        .y         (b_y),
        .carryin   (b_cin),
        .out_valid (b_out_valid),
        .out_ready (b_out_ready),
        .sum       (b_sum),
`ifdef CSA_OVERFLOW_EN
        .overflow  (b_ovf),
`endif
        .carryout  (b_cout)
    );

`ifndef CSA_OVERFLOW_EN
    assign a_ovf = 1'b0;
    assign b_ovf = 1'b0;
`endif

    // ---------------- backpressure driver ----------------
    always @(posedge clk) begin
        #1;
        case (rdy_mode)
            0:       a_out_ready = 1'b1;
            1:       a_out_ready = 1'($urandom_range(0, 1));
            default: a_out_ready = 1'b0;
        endcase
    end

    // ---------------- scoreboard monitors ----------------
    logic [17:0] mon_a_act, mon_a_exp;
    logic [11:0] mon_b_act, mon_b_exp;

    always @(negedge clk) begin
        if (!rst && a_out_valid && a_out_ready) begin
            mon_a_act = {a_ovf, a_cout, a_sum};
            n_vec++;
            if (exp_a.size() == 0) begin
                n_err++;
                $display("FAIL a_unexpected_output: got %h, required no output", mon_a_act);
            end else begin
                mon_a_exp = exp_a.pop_front();
`ifndef CSA_OVERFLOW_EN
                mon_a_exp[17] = 1'b0;
`endif
                if (mon_a_act !== mon_a_exp) begin
                    n_err++;
                    $display("FAIL a_result {ovf,cout,sum}: got %h, required %h", mon_a_act, mon_a_exp);
                end
            end
        end
    end

    always @(negedge clk) begin
        if (!rst && b_out_valid && b_out_ready) begin
            mon_b_act = {b_ovf, b_cout, b_sum};
            n_vec++;
            if (exp_b.size() == 0) begin
                n_err++;
                $display("FAIL b_unexpected_output: got %h, required no output", mon_b_act);
            end else begin
                mon_b_exp = exp_b.pop_front();
`ifndef CSA_OVERFLOW_EN
                mon_b_exp[11] = 1'b0;
`endif
                if (mon_b_act !== mon_b_exp) begin
                    n_err++;
                    $display("FAIL b_result {ovf,cout,sum}: got %h, required %h", mon_b_act, mon_b_exp);
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, required %h", name, act, exp);
        end
    endtask

    task automatic send_a(input logic [15:0] x, input logic [15:0] y, input logic c, input logic [17:0] exp);
        int  budget;
        bit  ok;
        a_x = x; a_y = y; a_cin = c; a_in_valid = 1'b1;
        exp_a.push_back(exp);
        budget = 0;
        ok = 1'b0;
        while (!ok && budget < 200) begin
            @(negedge clk);
            ok = a_in_ready;
            @(posedge clk);
            #1;
            budget++;
        end
        a_in_valid = 1'b0;
        if (!ok) begin
            n_vec++;
            n_err++;
            $display("FAIL a_accept_timeout: got in_ready=0, required 1 within 200 cycles");
            void'(exp_a.pop_back());
        end
    endtask

    task automatic send_b(input logic [9:0] x, input logic [9:0] y, input logic c, input logic [11:0] exp);
        int  budget;
        bit  ok;
        b_x = x; b_y = y; b_cin = c; b_in_valid = 1'b1;
        exp_b.push_back(exp);
        budget = 0;
        ok = 1'b0;
        while (!ok && budget < 200) begin
            @(negedge clk);
            ok = b_in_ready;
            @(posedge clk);
            #1;
            budget++;
        end
        b_in_valid = 1'b0;
        if (!ok) begin
            n_vec++;
            n_err++;
            $display("FAIL b_accept_timeout: got in_ready=0, required 1 within 200 cycles");
            void'(exp_b.pop_back());
        end
    endtask

    task automatic wait_drain();
        int budget;
        budget = 0;
        while ((exp_a.size() != 0 || exp_b.size() != 0) && budget < 500) begin
            @(posedge clk);
            budget++;
        end
        #1;
        if (exp_a.size() != 0 || exp_b.size() != 0) begin
            n_vec++;
            n_err++;
            $display("FAIL drain_timeout: got %0d/%0d pending, required 0/0", exp_a.size(), exp_b.size());
            exp_a.delete();
            exp_b.delete();
        end
    endtask

    function automatic logic [17:0] model_a(input logic [15:0] x, input logic [15:0] y, input logic c);
        logic [16:0] full;
        logic        ovf;
        full = {1'b0, x} + {1'b0, y} + {16'h0, c};
        ovf  = (x[15] == y[15]) && (full[15] != x[15]);
        return {ovf, full};
    endfunction

    // ---------------- directed tables ----------------
    logic [15:0] tx[10];
    logic [15:0] ty[10];
    logic        tc[10];
    logic [17:0] te[10];

    logic [9:0]  ux[4];
    logic [9:0]  uy[4];
    logic        uc[4];
    logic [11:0] ue[4];

    initial begin
        // {ovf, cout, sum}
        tx = '{16'h00FF, 16'hFFFF, 16'h1234, 16'h8000, 16'h0FFF, 16'h7FFF, 16'hFFFF, 16'h8000, 16'hAAAA, 16'h000F};
        ty = '{16'h0001, 16'h0000, 16'h4321, 16'h8000, 16'h0001, 16'h0001, 16'hFFFF, 16'hFFFF, 16'h5555, 16'h0001};
        tc = '{1'b0,     1'b1,     1'b0,     1'b0,     1'b0,     1'b0,     1'b1,     1'b0,     1'b1,     1'b0};
        te = '{{2'b00, 16'h0100}, {2'b01, 16'h0000}, {2'b00, 16'h5555}, {2'b11, 16'h0000}, {2'b00, 16'h1000},
               {2'b10, 16'h8000}, {2'b01, 16'hFFFF}, {2'b11, 16'h7FFF}, {2'b01, 16'h0000}, {2'b00, 16'h0010}};
        ux = '{10'h3FF, 10'h2AA, 10'h200, 10'h0FF};
        uy = '{10'h000, 10'h155, 10'h200, 10'h001};
        uc = '{1'b1,    1'b0,    1'b0,    1'b0};
        ue = '{{2'b01, 10'h000}, {2'b00, 10'h3FF}, {2'b11, 10'h000}, {2'b00, 10'h100}};
    end

    // ---------------- main sequence ----------------
    initial begin
        logic [15:0] rx, ry;
        logic        rc;

        rst = 1'b1;
        a_in_valid = 1'b0; a_x = '0; a_y = '0; a_cin = 1'b0; a_out_ready = 1'b1;
        b_in_valid = 1'b0; b_x = '0; b_y = '0; b_cin = 1'b0; b_out_ready = 1'b1;

        // reset held two cycles
        @(posedge clk);
        @(negedge clk);
        chk("reset_out_valid", 32'(a_out_valid), 32'd0);
        chk("reset_sum", 32'(a_sum), 32'd0);
        chk("reset_carryout", 32'(a_cout), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("reset_in_ready_a", 32'(a_in_ready), 32'd1);
        chk("reset_in_ready_b", 32'(b_in_ready), 32'd1);
        @(posedge clk);
        #1;

        // single op, latency exactly two cycles
        send_a(16'h00FF, 16'h0001, 1'b0, {2'b00, 16'h0100});
        @(negedge clk);
        chk("latency_stage1_not_valid", 32'(a_out_valid), 32'd0);
        @(negedge clk);
        chk("latency_stage2_valid", 32'(a_out_valid), 32'd1);
        wait_drain();

        // directed table, back to back
        for (int i = 0; i < 10; i++) send_a(tx[i], ty[i], tc[i], te[i]);
        wait_drain();

        // stream under random backpressure
        @(posedge clk);
        #1;
        rdy_mode = 1;
        for (int i = 0; i < 40; i++) begin
            rx = 16'($urandom_range(0, 65535));
            ry = 16'($urandom_range(0, 65535));
            rc = 1'($urandom_range(0, 1));
            send_a(rx, ry, rc, model_a(rx, ry, rc));
        end
        rdy_mode = 0;
        wait_drain();

        // two in flight with out_ready low: input blocked, sum held
        rdy_mode = 2;
        repeat (2) @(posedge clk);
        #1;
        send_a(16'h1111, 16'h2222, 1'b0, {2'b00, 16'h3333});
        send_a(16'h0F0F, 16'h0101, 1'b1, {2'b00, 16'h1011});
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("hold_in_ready", 32'(a_in_ready), 32'd0);
            chk("hold_out_valid", 32'(a_out_valid), 32'd1);
            chk("hold_sum", 32'(a_sum), 32'h3333);
        end
        @(posedge clk);
        #1;
        rdy_mode = 0;
        wait_drain();

        // reset mid-operation discards the in-flight op
        send_a(16'h0001, 16'h0001, 1'b0, {2'b00, 16'h0002});
        rst = 1'b1;
        exp_a.delete();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("post_reset_no_output", 32'(a_out_valid), 32'd0);
        end
        @(posedge clk);
        #1;

        // narrow last slice instance
        for (int i = 0; i < 4; i++) send_b(ux[i], uy[i], uc[i], ue[i]);
        wait_drain();

        repeat (3) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
